// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse issue path: descriptor payload, issue FSM
// state encoding and the saturating counter helper.
package pulse_pkg;

  localparam int unsigned N_CH_DEF     = 4;
  localparam int unsigned TS_W_DEF     = 32;
  localparam int unsigned LATE_TOL_DEF = 4;

  typedef struct packed {
    logic [31:0] start_time;
    logic [3:0]  channel;
    logic [15:0] duration;
    logic [7:0]  waveform_id;
    logic [15:0] amplitude;
  } pulse_descriptor_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TIME = 2'd1,
    ST_WAIT_CH   = 2'd2
  } pulse_issue_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pulse_timeline.sv
// Free-running timeline counter with synchronous clear, plus the modular due/late
// comparison of the held start time against the current timeline value.
module pulse_timeline
  import pulse_pkg::*;
#(
  parameter int unsigned TS_W     = TS_W_DEF,
  parameter int unsigned LATE_TOL = LATE_TOL_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [TS_W-1:0] start_time,
  output logic [TS_W-1:0] now,
  output logic            due_c,
  output logic            late_c
);

  logic [TS_W-1:0] now_d, now_q;
  logic [TS_W-1:0] diff_c;

  always_comb begin
    now_d = now_q + TS_W'(1);
    if (clr) now_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) now_q <= '0;
    else        now_q <= now_d;
  end

  // Sign bit of the modular difference decides due; this is what makes wrap-around work.
  assign diff_c = now_q - start_time;
  assign due_c  = ~diff_c[TS_W-1];
  assign late_c = due_c && (diff_c > TS_W'(LATE_TOL));
  assign now    = now_q;

endmodule

// File: rtl/pulse_issue_ctrl.sv
// Timed issue controller: pops descriptors from a FWFT FIFO, holds each until its start
// time, then issues it to its channel when free. Build option: PULSE_ISSUE_LATE_DROP_EN.
module pulse_issue_ctrl
  import pulse_pkg::*;
#(
  parameter int unsigned N_CH     = N_CH_DEF,
  parameter int unsigned TS_W     = TS_W_DEF,
  parameter int unsigned LATE_TOL = LATE_TOL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  pulse_descriptor_t fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic              timeline_clr,
  output logic [TS_W-1:0]   now,
  input  logic [N_CH-1:0]   ch_busy,
  output logic [N_CH-1:0]   ch_valid,
  output pulse_descriptor_t ch_desc,
  output logic              holding,
  output logic [31:0]       issue_count,
  output logic [15:0]       late_count,
  output logic [15:0]       drop_count
);

  localparam int unsigned CH_W = $clog2(N_CH);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] WAIT_TIME = ST_WAIT_TIME;
  localparam logic [1:0] WAIT_CH   = ST_WAIT_CH;

  logic [1:0]        state_d, state_q;
  pulse_descriptor_t hold_d, hold_q;
  logic [N_CH-1:0]   ch_valid_d, ch_valid_q;
  pulse_descriptor_t ch_desc_d, ch_desc_q;
  logic [31:0]       issue_cnt_d, issue_cnt_q;
  logic [15:0]       late_cnt_d, late_cnt_q;

  logic [CH_W-1:0]   hold_ch_c;
  logic [N_CH-1:0]   ch_onehot_c;
  logic              ch_free_c;
  logic              issue_go_c;
  logic              due_c;
  logic              late_c;

  pulse_timeline #(
    .TS_W     (TS_W),
    .LATE_TOL (LATE_TOL)
  ) u_timeline (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (timeline_clr),
    .start_time (TS_W'(hold_q.start_time)),
    .now        (now),
    .due_c      (due_c),
    .late_c     (late_c)
  );

  // A channel strobed this cycle counts as busy until its generator raises ch_busy.
  assign hold_ch_c   = hold_q.channel[CH_W-1:0];
  assign ch_onehot_c = N_CH'(1) << hold_ch_c;
  assign ch_free_c   = ~ch_busy[hold_ch_c] & ~ch_valid_q[hold_ch_c];
  assign issue_go_c  = ch_free_c &&
                       (((state_q == WAIT_TIME) && due_c) || (state_q == WAIT_CH));
  assign fifo_rd_en  = rst_n && (state_q == IDLE) && !fifo_empty;

`ifdef PULSE_ISSUE_LATE_DROP_EN
  logic [15:0] drop_cnt_d, drop_cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    ch_valid_d  = '0;
    ch_desc_d   = ch_desc_q;
    issue_cnt_d = issue_cnt_q;
    late_cnt_d  = late_cnt_q;
`ifdef PULSE_ISSUE_LATE_DROP_EN
    drop_cnt_d  = drop_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_rd_en) begin
          hold_d  = fifo_rd_data;
          state_d = WAIT_TIME;
        end
      end
      WAIT_TIME: if (due_c) state_d = WAIT_CH;
      WAIT_CH:   state_d = WAIT_CH;
      default:   state_d = IDLE;
    endcase
    if (issue_go_c) begin
      state_d = IDLE;
`ifdef PULSE_ISSUE_LATE_DROP_EN
      if (late_c) begin
        drop_cnt_d = sat_inc16(drop_cnt_q);
      end else begin
        ch_valid_d  = ch_onehot_c;
        ch_desc_d   = hold_q;
        issue_cnt_d = issue_cnt_q + 32'd1;
      end
`else
      ch_valid_d  = ch_onehot_c;
      ch_desc_d   = hold_q;
      issue_cnt_d = issue_cnt_q + 32'd1;
      if (late_c) late_cnt_d = sat_inc16(late_cnt_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      ch_valid_q  <= '0;
      ch_desc_q   <= '0;
      issue_cnt_q <= '0;
      late_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      ch_valid_q  <= ch_valid_d;
      ch_desc_q   <= ch_desc_d;
      issue_cnt_q <= issue_cnt_d;
      late_cnt_q  <= late_cnt_d;
    end
  end

`ifdef PULSE_ISSUE_LATE_DROP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end
  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

  assign ch_valid    = ch_valid_q;
  assign ch_desc     = ch_desc_q;
  assign holding     = (state_q != IDLE);
  assign issue_count = issue_cnt_q;
  assign late_count  = late_cnt_q;

endmodule

// File: tb/tb_pulse_issue_ctrl.sv
// Directed bench for pulse_issue_ctrl (TS_W=12 so wrap-around is reachable); honours
// PULSE_ISSUE_LATE_DROP_EN when the design is built with it.
module tb_pulse_issue_ctrl;
  import pulse_pkg::*;

  localparam int unsigned N_CH     = 4;
  localparam int unsigned TS_W     = 12;
  localparam int unsigned LATE_TOL = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  pulse_descriptor_t fifo_rd_data;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic              timeline_clr;
  logic [TS_W-1:0]   now;
  logic [N_CH-1:0]   ch_busy;
  logic [N_CH-1:0]   ch_valid;
  pulse_descriptor_t ch_desc;
  logic              holding;
  logic [31:0]       issue_count;
  logic [15:0]       late_count;
  logic [15:0]       drop_count;

  int total = 0;
  int bad   = 0;
  int exp_issue = 0;
  int exp_late  = 0;
  int exp_drop  = 0;

  pulse_issue_ctrl #(.N_CH(N_CH), .TS_W(TS_W), .LATE_TOL(LATE_TOL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .timeline_clr (timeline_clr),
    .now          (now),
    .ch_busy      (ch_busy),
    .ch_valid     (ch_valid),
    .ch_desc      (ch_desc),
    .holding      (holding),
    .issue_count  (issue_count),
    .late_count   (late_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pulse_descriptor_t mk(input int st, input int ch);
    pulse_descriptor_t d;
    d.start_time  = 32'(st);
    d.channel     = 4'(ch);
    d.duration    = 16'(st * 3 + 1);
    d.waveform_id = 8'(ch + 7);
    d.amplitude   = 16'hA000 | 16'(st);
    return d;
  endfunction

  task automatic clr_timeline();
    @(negedge clk);
    timeline_clr = 1'b1;
    @(negedge clk);
    timeline_clr = 1'b0;
  endtask

  task automatic wait_now(input int v);
    for (int i = 0; i < 5000; i++) begin
      if (now == TS_W'(v)) break;
      @(negedge clk);
    end
    chk("wait_now", 96'(now), 96'(v));
  endtask

  // Present d at the FIFO head until popped; returns just after the popping edge.
  task automatic offer(input string tag, input pulse_descriptor_t d);
    logic popped;
    popped = 1'b0;
    fifo_rd_data = d;
    fifo_empty = 1'b0;
    for (int i = 0; i < 3000 && !popped; i++) begin
      #1;
      if (fifo_rd_en) begin
        @(posedge clk);
        #1;
        popped = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    fifo_empty = 1'b1;
    chk({"pop_", tag}, 96'(popped), 96'(1));
  endtask

  task automatic quiet_until(input string tag, input int v);
    int n;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (|ch_valid) n++;
      if (now == TS_W'(v)) break;
    end
    chk({"quiet_", tag}, 96'(n), 96'(0));
    chk({"quiet_now_", tag}, 96'(now), 96'(v));
  endtask

  task automatic quiet_cycles(input string tag, input int cyc);
    int n;
    n = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (|ch_valid) n++;
    end
    chk({"quiet_", tag}, 96'(n), 96'(0));
  endtask

  // Wait for an issue strobe and check when, where and what was issued.
  task automatic expect_issue(input string tag, input int max, input int at_now,
                              input int ch, input pulse_descriptor_t d);
    logic got;
    logic [TS_W-1:0] t;
    logic [N_CH-1:0] bits;
    pulse_descriptor_t seen;
    got = 1'b0;
    t = '0;
    bits = '0;
    seen = '0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (|ch_valid) begin
        got = 1'b1;
        t = now;
        bits = ch_valid;
        seen = ch_desc;
      end
    end
    chk({"issued_", tag}, 96'(got), 96'(1));
    chk({"issue_now_", tag}, 96'(t), 96'(at_now));
    chk({"onehot_", tag}, 96'(bits), 96'(1 << ch));
    chk({"desc_", tag}, 96'(seen), 96'(d));
    exp_issue++;
    chk({"issue_cnt_", tag}, 96'(issue_count), 96'(exp_issue));
    chk({"late_cnt_", tag}, 96'(late_count), 96'(exp_late));
  endtask

  initial begin
    pulse_descriptor_t d;

    // reset: pop strobe suppressed even with data waiting
    rst_n = 1'b0;
    timeline_clr = 1'b0;
    ch_busy = '0;
    fifo_rd_data = mk(7, 1);
    fifo_empty = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rd_en_in_reset", 96'(fifo_rd_en), 96'(0));
    chk("now_in_reset", 96'(now), 96'(0));
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("now_after_reset", 96'(now), 96'(1));
    chk("holding_reset", 96'(holding), 96'(0));
    chk("valid_reset", 96'(ch_valid), 96'(0));
    chk("desc_reset", 96'(ch_desc), 96'(0));
    chk("issue_reset", 96'(issue_count), 96'(0));
    chk("late_reset", 96'(late_count), 96'(0));
    chk("drop_reset", 96'(drop_count), 96'(0));

    // basic: start 100 popped at now 50, strobe at now 101 for one cycle
    clr_timeline();
    wait_now(50);
    d = mk(100, 2);
    offer("basic", d);
    chk("holding_basic", 96'(holding), 96'(1));
    expect_issue("basic", 200, 101, 2, d);
    @(negedge clk);
    chk("one_cycle_basic", 96'(ch_valid), 96'(0));
    chk("desc_hold_basic", 96'(ch_desc), 96'(d));
    chk("idle_basic", 96'(holding), 96'(0));

    // late: start 10 popped at now 40
    clr_timeline();
    wait_now(40);
    d = mk(10, 0);
    offer("late", d);
`ifdef PULSE_ISSUE_LATE_DROP_EN
    quiet_cycles("late_drop", 6);
    exp_drop++;
    chk("drop_cnt_late", 96'(drop_count), 96'(exp_drop));
    chk("late_cnt_drop", 96'(late_count), 96'(exp_late));
    chk("issue_cnt_drop", 96'(issue_count), 96'(exp_issue));
`else
    exp_late++;
    expect_issue("late", 20, 42, 0, d);
    chk("drop_tied", 96'(drop_count), 96'(0));
`endif
    chk("idle_late", 96'(holding), 96'(0));

    // tolerance edge: decision at diff == LATE_TOL is not late
    clr_timeline();
    wait_now(39);
    d = mk(36, 1);
    offer("tol_edge", d);
    expect_issue("tol_edge", 20, 41, 1, d);

    // busy stall; a timeline clear does not disturb the WAIT_CH stall
    clr_timeline();
    ch_busy = 4'b0010;
    wait_now(10);
    d = mk(12, 1);
    offer("stall_a", d);
    quiet_until("stall_a", 30);
    timeline_clr = 1'b1;
    @(negedge clk);
    timeline_clr = 1'b0;
    chk("now_cleared_stall", 96'(now), 96'(0));
    chk("holding_stall", 96'(holding), 96'(1));
    quiet_until("stall_a2", 10);
    ch_busy = 4'b0000;
    expect_issue("stall_a", 3, 11, 1, d);
    ch_busy = 4'b0010;
    d = mk(13, 1);
    offer("stall_b", d);
    quiet_until("stall_b", 17);
    ch_busy = 4'b0000;
    expect_issue("stall_b", 3, 18, 1, d);

    // wrap-around: start 3 popped at now 4090 waits for the wrap
    clr_timeline();
    wait_now(4090);
    d = mk(3, 3);
    offer("wrap", d);
    expect_issue("wrap", 30, 4, 3, d);

    // timeline clear while holding a start time ahead of the restarted timeline
    clr_timeline();
    wait_now(990);
    d = mk(1005, 0);
    offer("tclr", d);
    wait_now(1000);
    chk("holding_tclr", 96'(holding), 96'(1));
    timeline_clr = 1'b1;
    @(negedge clk);
    timeline_clr = 1'b0;
    chk("now_tclr", 96'(now), 96'(0));
    expect_issue("tclr", 1100, 1006, 0, d);

    // reset while stalled in WAIT_CH
    clr_timeline();
    ch_busy = 4'b0001;
    wait_now(3);
    offer("rst_hold", mk(5, 0));
    wait_now(10);
    chk("holding_pre_rst", 96'(holding), 96'(1));
    rst_n = 1'b0;
    fifo_rd_data = mk(25, 2);
    fifo_empty = 1'b0;
    #1;
    chk("rd_en_rst_mid", 96'(fifo_rd_en), 96'(0));
    @(negedge clk);
    #1;
    chk("rd_en_rst_mid2", 96'(fifo_rd_en), 96'(0));
    chk("holding_rst_mid", 96'(holding), 96'(0));
    chk("valid_rst_mid", 96'(ch_valid), 96'(0));
    chk("issue_rst_mid", 96'(issue_count), 96'(0));
    chk("late_rst_mid", 96'(late_count), 96'(0));
    chk("drop_rst_mid", 96'(drop_count), 96'(0));
    chk("now_rst_mid", 96'(now), 96'(0));
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    ch_busy = 4'b0000;
    exp_issue = 0;
    exp_late = 0;
    exp_drop = 0;
    quiet_cycles("after_rst", 4);
    wait_now(20);
    d = mk(25, 2);
    offer("post_rst", d);
    expect_issue("post_rst", 20, 26, 2, d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_issue_ctrl.md
# pulse_issue_ctrl

Timed issue controller between the pulse-instruction FIFO and the per-channel pulse generators in the `ps_clk` domain. It pops pulse descriptors from the FIFO read port and holds each one until the free-running timeline counter reaches the descriptor's start time. It then dispatches the descriptor to its target channel once that channel is free. It replaces the constant `rd_en=1` drain, so no descriptor is lost or issued early.

## Interface
- `N_CH`, 4: number of pulse channels; power of two, 2..16.
- `TS_W`, 32: timeline and start-time width in bits.
- `LATE_TOL`, 4: cycles past `start_time` an issue may occur without counting as late.
- `clk` in 1: pulse-scheduler clock.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `fifo_rd_data` in `pulse_descriptor_t`: FIFO head, first-word fall-through; valid whenever `fifo_empty` is 0.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: pop strobe, combinational.
- `timeline_clr` in 1: synchronous clear of the timeline counter to 0.
- `now` out `TS_W`: current timeline value.
- `ch_busy` in `N_CH`: channel generator busy, one bit per channel.
- `ch_valid` out `N_CH`: one-hot issue strobe, registered.
- `ch_desc` out `pulse_descriptor_t`: descriptor bus shared by all channels; valid while any `ch_valid` bit is high.
- `holding` out 1: a descriptor is held, i.e. the state is not IDLE.
- `issue_count` out 32: number of descriptors issued.
- `late_count` out 16: number of descriptors issued late; saturates.
- `drop_count` out 16: number of descriptors dropped; saturates.

## Operation
- **Timeline counter:** `now` increments by 1 every cycle and wraps mod 2^TS_W. When `timeline_clr`=1, `now` is 0 on the next cycle.
- **Lateness arithmetic:**
  - `diff = now - hold.start_time`, computed mod 2^TS_W.
  - The held descriptor is *due* when `diff[TS_W-1]`=0.
  - The held descriptor is *late* when it is due and `diff > LATE_TOL`.
- **FSM states:** IDLE, WAIT_TIME, WAIT_CH.
  - **IDLE:** `fifo_rd_en = ~fifo_empty`. On a pop, `fifo_rd_data` is loaded into the `hold` register and the state goes to WAIT_TIME.
  - **WAIT_TIME:** stays until due. When due, goes to WAIT_CH; if the target channel is also free in the same cycle, issues directly (see below).
  - **WAIT_CH:** issues when `ch_busy[hold.channel]`=0 and the channel is not masked.
- **Issue:**
  - On the next cycle, `ch_valid[hold.channel]`=1 for exactly one cycle and `ch_desc`=`hold`.
  - `issue_count` increments.
  - `late_count` increments if the descriptor was late at the decision cycle.
  - The state returns to IDLE.
- **Channel mask:** a channel whose `ch_valid` bit is currently high is treated as busy. The generator must raise `ch_busy` in the cycle after its `ch_valid`.
- **`ch_desc` hold:** `ch_desc` keeps its last value when no `ch_valid` bit is high.
- **Concurrency:** IDLE may pop in the same cycle that `ch_valid` is high.
- **`timeline_clr` while holding:** the due test uses the cleared `now` from the next cycle onward. Start times far ahead of the new `now` simply wait.

## Timing
- **Reset values:** on `rst_n`=0 at a clock edge:
  - state = IDLE and any held descriptor is discarded;
  - `now`=0;
  - all counters = 0;
  - `ch_valid`=0, `ch_desc`=0, `holding`=0;
  - `fifo_rd_en`=0 while in reset.
- **Minimum latency:** pop at cycle t, decision at t+1, `ch_valid` at t+2. This holds when `start_time` ≤ `now` at t+1 and the channel is free.
- **Maximum throughput:** one descriptor per 2 cycles.
- **FIFO empty:** `fifo_rd_en` is never asserted while `fifo_empty`=1.
- **Busy and clear together:** if `ch_busy` is held high forever, the block stalls in WAIT_CH. `timeline_clr` has no effect on a WAIT_CH stall.
- **Wrap-around:** a `start_time` just past 2^TS_W-1 becomes due after `now` wraps, per the modular diff.

## Configuration
- **Macro:** `PULSE_ISSUE_LATE_DROP_EN`.
- **Defined:** a descriptor that is late at its decision cycle is dropped, not issued. No `ch_valid` is produced, `drop_count` increments, `late_count` is unchanged, and the state returns to IDLE.
- **Undefined:** late descriptors are issued and counted in `late_count`. `drop_count` is tied to 0.

## Structure
- **`pulse_pkg` contents:**
  - `pulse_descriptor_t`, packed: `start_time[31:0]`, `channel[3:0]`, `duration[15:0]`, `waveform_id[7:0]`, `amplitude[15:0]`;
  - the state enum `pulse_issue_state_e`;
  - the default `N_CH`/`TS_W` constants.
- **Sub-module:** `pulse_timeline`, containing the counter, `clr` and the due/late comparator. Everything else stays in `pulse_issue_ctrl`.

## Test plan
- **Basic issue:** `fifo_empty` falls with `start_time=100` at `now=50` → pop at once; `ch_valid[2]` rises exactly at `now=101` (decision cycle 100) for 1 cycle; `issue_count`=1, `late_count`=0.
- **Late:** `start_time=10` popped at `now=40`, `LATE_TOL=4` → issued at `now=42` with `late_count`=1. With `PULSE_ISSUE_LATE_DROP_EN`: no `ch_valid`, `drop_count`=1.
- **Busy stall:** `ch_busy[1]`=1 for 20 cycles after the descriptor is due → `ch_valid[1]` rises 1 cycle after `ch_busy[1]` falls. A back-to-back second ch1 descriptor is not issued until `busy` has risen and fallen again.
- **Wrap-around:** `TS_W=8`, `start_time=3`, popped at `now=250` → issued after wrap at `now=4`, not immediately.
- **Timeline clear:** `timeline_clr` pulsed at `now=1000` while holding `start_time=1005` → issued at `now=1006` of the restarted timeline.
- **Reset mid-hold:** synchronous `rst_n` pulse while in WAIT_CH → `holding`=0 next cycle, no `ch_valid`, counters 0; the next FIFO entry is popped normally.
